// File: rtl/cla_vector_gen.sv
// cla_vector_gen: streams CLA4 test-vector words (exhaustive or LFSR random) with expected sum/carry/PG/GG.
module cla_vector_gen #(
  parameter int          RAND_COUNT = 256,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic        vec_ready,
  output logic        vec_valid,
  output logic [15:0] vec_data,
  output logic [9:0]  vec_count,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;
  state_t      r_state, w_state_nxt;
  logic        r_mode;
  logic [8:0]  r_idx;
  logic [15:0] r_lfsr;
  logic        w_go, w_hs, w_last;
  logic [15:0] w_lfsr_nxt;
  logic [8:0]  w_idx_nxt, w_abc_nxt, w_abc_first;

  function automatic logic [15:0] vec_word(input logic [8:0] abc);
    logic [3:0] a, b, p, g;
    logic [4:0] s;
    a = abc[8:5];
    b = abc[4:1];
    s = {1'b0, a} + {1'b0, b} + {4'd0, abc[0]};
    p = a ^ b;
    g = a & b;
    return {a, b, abc[0], s[3:0], s[4], &p,
            g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (&p[3:1] & g[0])};
  endfunction

  // vec_valid is exactly "in RUN": it rises one cycle after start and falls only on the final handshake
  assign vec_valid   = (r_state == RUN);
  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign w_go        = start && (r_state != RUN);
  assign w_hs        = vec_valid && vec_ready;
  assign w_last      = r_mode ? (vec_count == 10'(RAND_COUNT - 1)) : (r_idx == 9'd511);
  assign w_lfsr_nxt  = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  assign w_idx_nxt   = r_idx + 9'd1;
  assign w_abc_nxt   = r_mode ? w_lfsr_nxt[8:0] : w_idx_nxt;
  assign w_abc_first = mode ? SEED[8:0] : 9'd0;

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_go ? RUN : (w_hs && w_last) ? DONE : r_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode    <= 1'b0;
      r_idx     <= 9'd0;
      r_lfsr    <= SEED;
      vec_data  <= 16'd0;
      vec_count <= 10'd0;
    end else if (w_go) begin
      r_mode    <= mode;
      r_idx     <= 9'd0;
      r_lfsr    <= SEED;
      vec_data  <= vec_word(w_abc_first);
      vec_count <= 10'd0;
    end else if (w_hs) begin
      vec_count <= vec_count + 10'd1;
      if (!w_last) begin
        r_idx    <= w_idx_nxt;
        r_lfsr   <= w_lfsr_nxt;
        vec_data <= vec_word(w_abc_nxt);
      end
    end
  end
endmodule

// File: tb/tb_cla_vector_gen.sv
// tb_cla_vector_gen: randomized stream checks of cla_vector_gen against an arithmetic reference model.
module tb_cla_vector_gen;
  localparam int RC = 256;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, mode = 1'b0, vec_ready = 1'b0;
  logic        vec_valid, busy, done;
  logic [15:0] vec_data;
  logic [9:0]  vec_count;
  int          n_chk = 0, n_fail = 0;

  cla_vector_gen #(.RAND_COUNT(RC), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .vec_ready(vec_ready),
    .vec_valid(vec_valid), .vec_data(vec_data), .vec_count(vec_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // group propagate = every bit sum is 1; group generate = carry out of A+B with no carry in
  function automatic logic [15:0] model_word(input logic [8:0] abc);
    int a, b, ci, s;
    a  = int'(abc[8:5]);
    b  = int'(abc[4:1]);
    ci = int'(abc[0]);
    s  = a + b + ci;
    return 16'((a << 12) | (b << 8) | (ci << 7) | ((s % 16) << 3) | ((s / 16) << 2)
               | (((a ^ b) == 15 ? 1 : 0) << 1) | ((a + b) > 15 ? 1 : 0));
  endfunction

  task automatic stream(input logic m, input int rmode, input int stop_at);
    logic [15:0] exp[$];
    logic [15:0] l;
    logic        rdy;
    int          n, cyc, nvec;
    nvec = m ? RC : 512;
    l = 16'hACE1;
    for (int i = 0; i < nvec; i++) begin
      exp.push_back(m ? model_word(l[8:0]) : model_word(i[8:0]));
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_clear", done, 0);
    n = 0;
    cyc = 0;
    while (n < nvec && cyc < 4000) begin
      if (n == stop_at) break;
      mode = 1'($urandom);
      chk("valid", vec_valid, 1);
      chk("data", vec_data, exp[n]);
      chk("count", vec_count, n);
      if (!m && n == 0)      chk("exh_first", vec_data, 16'h0000);
      if (!m && n == 1)      chk("exh_second", vec_data, 16'h0088);
      if (!m && n == 'h1E1)  chk("exh_1e1", vec_data, 16'hF086);
      if (!m && n == 511)    chk("exh_last", vec_data, 16'hFFFD);
      if (m && n == 0)       chk("rand_first", vec_data, 16'h70C0);
      rdy = (rmode == 0) ? 1'b1 : (rmode == 2) ? !(cyc >= 200 && cyc < 203)
                                               : ($urandom_range(0, 9) < 7);
      vec_ready = rdy;
      start = (n == nvec - 1 && rdy) || ($urandom_range(0, 15) == 0);
      if (rdy) n++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (n == stop_at) return;
    chk("handshakes", n, nvec);
    if (rmode == 0) chk("cycles", cyc, nvec);
    chk("valid_end", vec_valid, 0);
    chk("done_end", done, 1);
    chk("busy_end", busy, 0);
    chk("count_end", vec_count, nvec);
    chk("data_hold", vec_data, exp[nvec-1]);
    @(negedge clk);
    chk("done_stays", done, 1);
    chk("count_stays", vec_count, nvec);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, vec_valid, 0);
    chk({tag, "_data"}, vec_data, 0);
    chk({tag, "_count"}, vec_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #12 check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    stream(1'b0, 0, -1);
    stream(1'b0, 2, -1);
    stream(1'b1, 1, -1);
    stream(1'b0, 0, 100);
    reset = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b1;
    stream(1'b0, 1, -1);
    stream(1'b1, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
